keypad_scanner: RTL and testbench

Drives the column lines of the 4x4 matrix keypad on GPIO_1, samples the row lines, debounces a single key press, and presents a one-entry buffered key code to peripheral_controller. It sits directly upstream of peripheral_controller's keypad input and runs on the divided clock `clkd` (about 500 Hz). Bounce and ghost filtering happen here, so the controller sees one clean event per physical press.

---
 rtl/keypad_scanner_if.sv | 31 +++
 rtl/keypad_scanner.sv | 157 +++++++++++++++
 tb/tb_keypad_scanner.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
// Buffered key event bus between keypad_scanner (master) and its consumer
// (slave, normally peripheral_controller).
//   key_valid : buffer holds an unread key
//   key_code  : buffered key, row_index*4 + col_index
//   key_ack   : consumer pulse that empties the buffer
//   overrun   : a key was overwritten before being acked (sticky until ack)
//   key_down  : level, high while the accepted key is still held
interface keypad_scanner_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ack;
    logic       overrun;
    logic       key_down;

    modport master (
        output key_valid,
        output key_code,
        output overrun,
        output key_down,
        input  key_ack
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  overrun,
        input  key_down,
        output key_ack
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 matrix keypad one column at a time, debounces a single press,
// and holds the resulting key code in a one-entry buffer until acked.
// Ports:
//   clk    : block clock (divided clkd, ~500 Hz)
//   reset  : synchronous, active-low
//   rows   : row inputs, pulled up; 0 = key closed on the driven column
//   cols   : column drive, exactly one bit low
//   kbus   : key buffer bus (master side), see keypad_scanner_if
module keypad_scanner #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int DEBOUNCE_COUNT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         rows,
    output logic [3:0]         cols,
    keypad_scanner_if.master   kbus
);

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] DB_TARGET   = 8'(DEBOUNCE_COUNT);

    state_t     state_q;
    logic [1:0] col_q;
    logic [3:0] cols_q;
    logic [3:0] settle_q;
    logic [7:0] db_q;
    logic [3:0] pat_q;
    logic       key_valid_q;
    logic [3:0] key_code_q;
    logic       overrun_q;
    logic       key_down_q;

    logic [1:0] col_d;
    logic [3:0] settle_d;
    logic [7:0] db_d;
    logic       rows_idle;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    // Lowest-numbered closed row wins when several rows read low.
    function automatic logic [1:0] low_row(input logic [3:0] p);
        if (!p[0])      return 2'd0;
        else if (!p[1]) return 2'd1;
        else if (!p[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    assign col_d     = col_q + 2'd1;   // natural 2-bit wrap 3 -> 0
    assign settle_d  = sat_inc4(settle_q);
    assign db_d      = sat_inc8(db_q);
    assign rows_idle = (rows == 4'hF);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= SCAN;
            col_q       <= 2'd0;
            cols_q      <= 4'b1110;
            settle_q    <= 4'd0;
            db_q        <= 8'd0;
            pat_q       <= 4'hF;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            overrun_q   <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            // Ack handling first; an acceptance below overrides it on the same edge.
            if (kbus.key_ack && key_valid_q) begin
                key_valid_q <= 1'b0;
                overrun_q   <= 1'b0;
            end

            case (state_q)
                SCAN: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_q <= 4'd0;
                        if (rows_idle) begin
                            col_q  <= col_d;
                            cols_q <= col_drive(col_d);
                        end else begin
                            pat_q   <= rows;
                            db_q    <= 8'd1;
                            state_q <= PRESS_DB;
                        end
                    end else begin
                        settle_q <= settle_d;
                    end
                end

                PRESS_DB: begin
                    if (rows_idle) begin
                        settle_q <= 4'd0;
                        state_q  <= SCAN;
                    end else if (rows != pat_q) begin
                        pat_q <= rows;
                        db_q  <= 8'd1;
                    end else begin
                        db_q <= db_d;
                        if (db_d == DB_TARGET) begin
                            key_code_q  <= {low_row(pat_q), col_q};
                            key_valid_q <= 1'b1;
                            key_down_q  <= 1'b1;
                            // Unread key being replaced without an ack this cycle.
                            overrun_q   <= key_valid_q && !kbus.key_ack;
                            state_q     <= HELD;
                        end
                    end
                end

                HELD: begin
                    // Pattern changes while held are deliberately ignored.
                    if (rows_idle) begin
                        db_q    <= 8'd1;
                        state_q <= RELEASE_DB;
                    end
                end

                RELEASE_DB: begin
                    if (rows_idle) begin
                        db_q <= db_d;
                        if (db_d == DB_TARGET) begin
                            key_down_q <= 1'b0;
                            col_q      <= col_d;
                            cols_q     <= col_drive(col_d);
                            settle_q   <= 4'd0;
                            state_q    <= SCAN;
                        end
                    end else begin
                        state_q <= HELD;
                    end
                end

                default: state_q <= SCAN;
            endcase
        end
    end

    assign cols           = cols_q;
    assign kbus.key_valid = key_valid_q;
    assign kbus.key_code  = key_code_q;
    assign kbus.overrun   = overrun_q;
    assign kbus.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    int         tests_run;
    int         tests_failed;

    keypad_scanner_if kbus();

    keypad_scanner #(
        .SETTLE_CYCLES (2),
        .DEBOUNCE_COUNT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rows (rows),
        .cols (cols),
        .kbus (kbus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // After this, column 0 is driven with settle count 0.
    task automatic do_reset();
        reset = 1'b0;
        rows = 4'hF;
        kbus.key_ack = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_seq [9];
        exp_seq = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011,
                    4'b1011, 4'b0111, 4'b0111, 4'b1110};
        reset = 1'b0;
        rows = 4'hF;
        kbus.key_ack = 1'b0;
        tick(3);
        tests_run++;
        if ({kbus.key_valid, kbus.key_code, kbus.overrun, kbus.key_down} !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b c=%h o=%b d=%b, want all 0",
                     kbus.key_valid, kbus.key_code, kbus.overrun, kbus.key_down);
        end
        tests_run++;
        if (cols !== 4'b1110) begin
            tests_failed++;
            $display("FAIL reset_cols: got %b want 1110", cols);
        end
        reset = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick(1);
            tests_run++;
            if (cols !== exp_seq[i]) begin
                tests_failed++;
                $display("FAIL idle_cols[%0d]: got %b want %b", i, cols, exp_seq[i]);
            end
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        tick(2);                 // column 1 freshly driven
        rows = 4'b1011;          // row 2
        tick(4);                 // settle, sample edge, db2, db3
        tests_run++;
        if (kbus.key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL press_early: key_valid got %b want 0", kbus.key_valid);
        end
        tick(1);
        tests_run++;
        if ({kbus.key_valid, kbus.key_code, kbus.key_down} !== {1'b1, 4'h9, 1'b1}) begin
            tests_failed++;
            $display("FAIL press_accept: got v=%b c=%h d=%b want v=1 c=9 d=1",
                     kbus.key_valid, kbus.key_code, kbus.key_down);
        end
        tick(15);
        tests_run++;
        if ({cols, kbus.key_down, kbus.key_valid} !== {4'b1101, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL press_hold: got cols=%b d=%b v=%b want 1101 1 1",
                     cols, kbus.key_down, kbus.key_valid);
        end
        rows = 4'hF;
        tick(3);
        tests_run++;
        if (kbus.key_down !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_early: key_down got %b want 1", kbus.key_down);
        end
        tick(1);
        tests_run++;
        if ({kbus.key_down, cols} !== {1'b0, 4'b1011}) begin
            tests_failed++;
            $display("FAIL release_done: got d=%b cols=%b want 0 1011", kbus.key_down, cols);
        end
        kbus.key_ack = 1'b1;
        tick(1);
        kbus.key_ack = 1'b0;
        tests_run++;
        if (kbus.key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL press_ack: key_valid got %b want 0", kbus.key_valid);
        end
    endtask

    task automatic test_bounce();
        int rises;
        logic prev_v;
        do_reset();
        rises = 0;
        prev_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rows = ((i / 2) % 2 == 0) ? 4'b1110 : 4'b1111;
            tick(1);
            tests_run++;
            if (kbus.key_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL bounce_early[%0d]: key_valid got %b want 0", i, kbus.key_valid);
            end
            prev_v = kbus.key_valid;
        end
        rows = 4'b1110;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (kbus.key_valid && !prev_v) rises++;
            prev_v = kbus.key_valid;
        end
        tests_run++;
        if (rises !== 1) begin
            tests_failed++;
            $display("FAIL bounce_count: acceptances got %0d want 1", rises);
        end
        tests_run++;
        if ({kbus.key_valid, kbus.key_code, kbus.overrun} !== {1'b1, 4'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL bounce_code: got v=%b c=%h o=%b want 1 0 0",
                     kbus.key_valid, kbus.key_code, kbus.overrun);
        end
        rows = 4'hF;
        tick(6);
    endtask

    task automatic test_overrun();
        do_reset();
        tick(2);                 // column 1
        rows = 4'b1101;          // row 1 -> key 5
        tick(5);
        tests_run++;
        if ({kbus.key_valid, kbus.key_code, kbus.overrun} !== {1'b1, 4'h5, 1'b0}) begin
            tests_failed++;
            $display("FAIL ovr_first: got v=%b c=%h o=%b want 1 5 0",
                     kbus.key_valid, kbus.key_code, kbus.overrun);
        end
        rows = 4'hF;
        tick(4);                 // release accepted, column 2 freshly driven
        rows = 4'b1011;          // row 2 -> key A
        tick(5);
        tests_run++;
        if ({kbus.key_valid, kbus.key_code, kbus.overrun} !== {1'b1, 4'hA, 1'b1}) begin
            tests_failed++;
            $display("FAIL ovr_second: got v=%b c=%h o=%b want 1 A 1",
                     kbus.key_valid, kbus.key_code, kbus.overrun);
        end
        kbus.key_ack = 1'b1;
        tick(1);
        kbus.key_ack = 1'b0;
        tests_run++;
        if ({kbus.key_valid, kbus.overrun} !== 2'b00) begin
            tests_failed++;
            $display("FAIL ovr_ack: got v=%b o=%b want 0 0", kbus.key_valid, kbus.overrun);
        end
        rows = 4'hF;
        tick(6);
    endtask

    task automatic test_ack_accept_same_edge();
        do_reset();
        tick(6);                 // column 3
        rows = 4'b1110;          // row 0 -> key 3
        tick(5);
        rows = 4'hF;
        tick(4);                 // release, column 0 freshly driven
        tick(4);                 // column 2 freshly driven
        rows = 4'b0111;          // row 3 -> key E
        tick(4);
        tests_run++;
        if ({kbus.key_valid, kbus.key_code} !== {1'b1, 4'h3}) begin
            tests_failed++;
            $display("FAIL simul_pre: got v=%b c=%h want 1 3", kbus.key_valid, kbus.key_code);
        end
        kbus.key_ack = 1'b1;     // sampled on the acceptance edge
        tick(1);
        kbus.key_ack = 1'b0;
        tests_run++;
        if ({kbus.key_valid, kbus.key_code, kbus.overrun} !== {1'b1, 4'hE, 1'b0}) begin
            tests_failed++;
            $display("FAIL simul_accept: got v=%b c=%h o=%b want 1 E 0",
                     kbus.key_valid, kbus.key_code, kbus.overrun);
        end
        rows = 4'hF;
        tick(6);
    endtask

    task automatic test_multirow_and_reset();
        do_reset();
        tick(6);                 // column 3
        rows = 4'b1010;          // rows 0 and 2 closed: row 0 wins -> key 3
        tick(5);
        tests_run++;
        if ({kbus.key_valid, kbus.key_code} !== {1'b1, 4'h3}) begin
            tests_failed++;
            $display("FAIL multi_1010: got v=%b c=%h want 1 3", kbus.key_valid, kbus.key_code);
        end
        do_reset();
        tick(6);
        rows = 4'b0101;          // rows 1 and 3 closed: row 1 wins -> key 7
        tick(5);
        tests_run++;
        if ({kbus.key_valid, kbus.key_code} !== {1'b1, 4'h7}) begin
            tests_failed++;
            $display("FAIL multi_0101: got v=%b c=%h want 1 7", kbus.key_valid, kbus.key_code);
        end
        do_reset();
        tick(6);
        rows = 4'b1010;
        tick(3);                 // now in PRESS_DB with db count 2
        reset = 1'b0;
        tick(1);
        tests_run++;
        if ({cols, kbus.key_valid, kbus.key_down} !== {4'b1110, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL mid_reset: got cols=%b v=%b d=%b want 1110 0 0",
                     cols, kbus.key_valid, kbus.key_down);
        end
        reset = 1'b1;
        rows = 4'hF;
        tick(5);
        tests_run++;
        if (kbus.key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_after: key_valid got %b want 0", kbus.key_valid);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b0;
        rows = 4'hF;
        kbus.key_ack = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_overrun();
        test_ack_accept_same_edge();
        test_multirow_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
